// File: rtl/result_byte_serializer_pkg.sv
// ---------------------------------------------------------------------------
// result_byte_serializer_pkg
// Purpose : Shared constants and helpers for the result byte serializer:
//           FSM state encodings and sizing functions used by the top level
//           and the word FIFO.
// Contents: ST_IDLE / ST_SEND / ST_CSUM state encodings,
//           bytes_per_word(), byte_cnt_width(), addr_width().
// ---------------------------------------------------------------------------
package result_byte_serializer_pkg;

    // FSM encodings. ST_CSUM is only reachable when RESULT_SER_CHECKSUM_EN is defined.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_CSUM = 2'd2;

    // Number of bytes in one W-bit result word.
    function automatic int bytes_per_word(input int w);
        return w / 8;
    endfunction

    // Width of the byte counter; at least 1 bit so W=8 still gets a real signal.
    function automatic int byte_cnt_width(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

    // FIFO address width for a power-of-two depth.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/result_byte_serializer_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
// Purpose : W x DEPTH synchronous FIFO with a registered (block-RAM style)
//           read port. dout always presents the head word once it is
//           readable, so the consumer can pop and capture dout in one cycle.
// Ports   : clk   - clock
//           rst   - synchronous active-low reset (pointers only)
//           push  - write din (ignored when full)
//           din   - write data, W bits
//           pop   - remove head word (ignored when empty)
//           full  - DEPTH words stored
//           empty - no readable word at dout
//           dout  - head word, registered
// ---------------------------------------------------------------------------
module result_fifo
    import result_byte_serializer_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);

    localparam int AW = addr_width(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] dout_q;

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         fresh_q, fresh_d;
    logic [AW:0]  count;
    logic         do_push;
    logic         do_pop;

    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        full     = (count == (AW+1)'(DEPTH));
        // A word written at the last edge has not yet reached the registered
        // read port, so it is hidden until the following cycle.
        empty    = (count == '0) || ((count == (AW+1)'(1)) && fresh_q);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        fresh_d  = do_push;
        dout     = dout_q;
    end

    // Storage and read port: no reset, so this maps onto block RAM.
    // Reading at the next read pointer keeps dout pointing at the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
        dout_q <= mem[rd_ptr_d[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fresh_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fresh_q  <= fresh_d;
        end
    end

endmodule

// File: rtl/result_byte_serializer.sv
// ---------------------------------------------------------------------------
// result_byte_serializer
// Purpose : Captures W-bit results from the upstream arithmetic circuit,
//           buffers them in a DEPTH-entry FIFO and emits each word as a
//           ready/valid byte stream, LSB byte first, with a last-byte marker.
// Config  : define RESULT_SER_CHECKSUM_EN to append one checksum byte (XOR of
//           the word's bytes) after each word; out_last then moves to it.
// Ports   : clk       - clock, rising edge
//           rst       - synchronous active-low reset (0 = reset)
//           in_valid  - result strobe from upstream
//           in_data   - result word, W bits, raw two's complement bits
//           in_ready  - FIFO can accept (= !full)
//           out_valid - out_data holds a valid byte
//           out_ready - downstream accepts the current byte
//           out_data  - current byte
//           out_last  - current byte is the final byte of its word
//           overflow  - sticky: a word arrived while full and was dropped
// ---------------------------------------------------------------------------
module result_byte_serializer
    import result_byte_serializer_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         out_last,
    output logic         overflow
);

    localparam int             NB       = bytes_per_word(W);
    localparam int             CW       = byte_cnt_width(NB);
    localparam logic [CW-1:0]  LAST_IDX = CW'(NB - 1);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic          overflow_q, overflow_d;
`ifdef RESULT_SER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [W-1:0]  fifo_dout;

    result_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .din   (in_data),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    // Next-state logic. "Load" means pop the FIFO head into the shifter and
    // start a new word; it happens from IDLE and directly after the final
    // byte of a word so consecutive words stream without a bubble.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        overflow_d = overflow_q | (in_valid & fifo_full);
        fifo_pop   = 1'b0;
`ifdef RESULT_SER_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_dout;
                    byte_cnt_d = '0;
                    state_d    = ST_SEND;
`ifdef RESULT_SER_CHECKSUM_EN
                    csum_d     = 8'h00;
`endif
                end
            end

            ST_SEND: begin
                if (out_ready) begin
                    shift_d    = shift_q >> 8;
                    byte_cnt_d = byte_cnt_q + CW'(1);
`ifdef RESULT_SER_CHECKSUM_EN
                    csum_d     = csum_q ^ shift_q[7:0];
                    if (byte_cnt_q == LAST_IDX) begin
                        byte_cnt_d = '0;
                        state_d    = ST_CSUM;
                    end
`else
                    if (byte_cnt_q == LAST_IDX) begin
                        if (!fifo_empty) begin
                            fifo_pop   = 1'b1;
                            shift_d    = fifo_dout;
                            byte_cnt_d = '0;
                        end else begin
                            state_d    = ST_IDLE;
                        end
                    end
`endif
                end
            end

`ifdef RESULT_SER_CHECKSUM_EN
            ST_CSUM: begin
                if (out_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_d    = fifo_dout;
                        byte_cnt_d = '0;
                        csum_d     = 8'h00;
                        state_d    = ST_SEND;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs come straight from registered state, so they stay stable
    // whenever out_ready is low.
    always_comb begin
        in_ready  = !fifo_full;
        overflow  = overflow_q;
        out_valid = (state_q != ST_IDLE);
        out_data  = 8'h00;
        out_last  = 1'b0;
        if (state_q == ST_SEND) begin
            out_data = shift_q[7:0];
`ifndef RESULT_SER_CHECKSUM_EN
            out_last = (byte_cnt_q == LAST_IDX);
`endif
        end
`ifdef RESULT_SER_CHECKSUM_EN
        if (state_q == ST_CSUM) begin
            out_data = csum_q;
            out_last = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            overflow_q <= 1'b0;
`ifdef RESULT_SER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            overflow_q <= overflow_d;
`ifdef RESULT_SER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

endmodule
